// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter and sequences the instruction
// fetch datapath between a synchronous 256x16 instruction memory and decode.
//
// Ports:
//   clk              clock, all state changes on posedge
//   reset            synchronous, active-high
//   start            pulse, begins fetching from pc when idle
//   redirect_valid   load redirect_target into pc, flush any in-flight fetch
//   redirect_target  new fetch address
//   mem_addr         instruction memory address (combinational, equals pc)
//   mem_rdata        memory read data, valid the cycle after mem_addr is sampled
//   instr_valid      instr_data/instr_pc hold a fetched instruction
//   instr_ready      decode accepts the instruction when high with instr_valid
//   instr_data       fetched instruction word (registered)
//   instr_pc         address instr_data came from (registered)
//   pc               current fetch address
//   busy             state decode: fetch in progress
//   halted           state decode: stopped on a halt opcode
//
// Optional feature: define FETCH_HALT_DETECT_EN to stop fetching after a
// delivered word whose opcode field [15:12] is 4'hF. Without it, halted is 0.

module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_target,
    output logic [7:0]  mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_data,
    output logic [7:0]  instr_pc,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted
);

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_W-1:0]    pc_next;
    logic [ADDR_W-1:0]    instr_pc_next;
    logic [INSTR_W-1:0]   instr_data_next;
    logic                 instr_valid_next;
    logic                 halt_pending;
    logic                 halt_pending_next;
    logic                 halt_word_c;

    // Halt opcode detection on the word returning from memory.
`ifdef FETCH_HALT_DETECT_EN
    assign halt_word_c = (mem_rdata[15:12] == 4'hF);
    assign halted      = (state == HALT);
`else
    assign halt_word_c = 1'b0;
    assign halted      = 1'b0;
`endif

    assign mem_addr = pc;
    assign busy     = (state == REQ) || (state == RESP) || (state == HOLD);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= '0;
            instr_valid  <= 1'b0;
            instr_data   <= '0;
            instr_pc     <= '0;
            halt_pending <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            instr_valid  <= instr_valid_next;
            instr_data   <= instr_data_next;
            instr_pc     <= instr_pc_next;
            halt_pending <= halt_pending_next;
        end
    end

    // Next-state and datapath update; redirect overrides the normal flow.
    always_comb begin
        state_next        = state;
        pc_next           = pc;
        instr_valid_next  = instr_valid;
        instr_data_next   = instr_data;
        instr_pc_next     = instr_pc;
        halt_pending_next = halt_pending;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = RESP;
            end
            RESP: begin
                instr_data_next   = mem_rdata;
                instr_pc_next     = pc;
                instr_valid_next  = 1'b1;
                pc_next           = pc + ADDR_W'(1);
                halt_pending_next = halt_word_c;
                state_next        = HOLD;
            end
            HOLD: begin
                if (instr_ready) begin
                    instr_valid_next = 1'b0;
                    state_next       = halt_pending ? HALT : REQ;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // In IDLE a redirect only sets the start address; elsewhere it
        // flushes the in-flight word and restarts fetching at the target.
        if (redirect_valid) begin
            pc_next = redirect_target;
            if (state != IDLE) begin
                state_next        = REQ;
                instr_valid_next  = 1'b0;
                instr_data_next   = instr_data;
                instr_pc_next     = instr_pc;
                halt_pending_next = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a
// randomized ready/redirect run checked against an instruction-stream model.

module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_target = 8'h00;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_data;
    logic [7:0]  instr_pc;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .pc              (pc),
        .busy            (busy),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; redirect_valid = 1'b0;
        redirect_target = 8'h00; instr_ready = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h expected 00", pc); end
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL reset_mem_addr: got %h expected 00", mem_addr); end
        total++; if (instr_data !== 16'h0000) begin bad++; $display("FAIL reset_data: got %h expected 0000", instr_data); end
        total++; if (instr_pc !== 8'h00) begin bad++; $display("FAIL reset_instr_pc: got %h expected 00", instr_pc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b expected 0", halted); end
    endtask

    task automatic test_basic;
        do_reset;
        mem[0] = 16'h1234; mem[1] = 16'hABCD;
        instr_ready = 1'b1; start = 1'b1;
        tick; start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_req: got %b expected 1", busy); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_req: got %b expected 0", instr_valid); end
        tick;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_resp: got %b expected 0", instr_valid); end
        tick;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL basic_valid0: got %b expected 1", instr_valid); end
        total++; if (instr_data !== 16'h1234) begin bad++; $display("FAIL basic_data0: got %h expected 1234", instr_data); end
        total++; if (instr_pc !== 8'h00) begin bad++; $display("FAIL basic_ipc0: got %h expected 00", instr_pc); end
        total++; if (pc !== 8'h01) begin bad++; $display("FAIL basic_pc0: got %h expected 01", pc); end
        tick;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL basic_drop: got %b expected 0", instr_valid); end
        tick; tick;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL basic_valid1: got %b expected 1", instr_valid); end
        total++; if (instr_data !== 16'hABCD) begin bad++; $display("FAIL basic_data1: got %h expected abcd", instr_data); end
        total++; if (instr_pc !== 8'h01) begin bad++; $display("FAIL basic_ipc1: got %h expected 01", instr_pc); end
        instr_ready = 1'b0;
    endtask

    task automatic test_stall;
        do_reset;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        for (int i = 0; i < 5; i++) begin
            tick;
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, instr_valid); end
            total++; if (instr_data !== 16'h1234) begin bad++; $display("FAIL stall_data[%0d]: got %h expected 1234", i, instr_data); end
            total++; if (instr_pc !== 8'h00) begin bad++; $display("FAIL stall_ipc[%0d]: got %h expected 00", i, instr_pc); end
            total++; if (pc !== 8'h01) begin bad++; $display("FAIL stall_pc[%0d]: got %h expected 01", i, pc); end
            total++; if (mem_addr !== 8'h01) begin bad++; $display("FAIL stall_addr[%0d]: got %h expected 01", i, mem_addr); end
        end
        instr_ready = 1'b1; tick;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL stall_release: got %b expected 0", instr_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy: got %b expected 1", busy); end
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap;
        logic [7:0] exp;
        do_reset;
        redirect_valid = 1'b1; redirect_target = 8'hFE; tick; redirect_valid = 1'b0;
        total++; if (pc !== 8'hFE) begin bad++; $display("FAIL wrap_idle_pc: got %h expected fe", pc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle_busy: got %b expected 0", busy); end
        instr_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
        tick;
        exp = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid[%0d]: got %b expected 1", i, instr_valid); end
            total++; if (instr_pc !== exp) begin bad++; $display("FAIL wrap_ipc[%0d]: got %h expected %h", i, instr_pc, exp); end
            total++; if (instr_data !== mem[exp]) begin bad++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, instr_data, mem[exp]); end
            exp = exp + 8'd1;
            tick; tick;
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_resp;
        do_reset;
        instr_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
        tick;
        redirect_valid = 1'b1; redirect_target = 8'h40; tick; redirect_valid = 1'b0;
        total++; if (mem_addr !== 8'h40) begin bad++; $display("FAIL redir_addr: got %h expected 40", mem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b expected 0", instr_valid); end
        tick;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_resp: got %b expected 0", instr_valid); end
        tick;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL redir_valid: got %b expected 1", instr_valid); end
        total++; if (instr_pc !== 8'h40) begin bad++; $display("FAIL redir_ipc: got %h expected 40", instr_pc); end
        total++; if (instr_data !== mem[8'h40]) begin bad++; $display("FAIL redir_data: got %h expected %h", instr_data, mem[8'h40]); end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_hold;
        do_reset;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL rsthold_pre: got %b expected 1", instr_valid); end
        reset = 1'b1; tick; reset = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rsthold_valid: got %b expected 0", instr_valid); end
        total++; if (instr_data !== 16'h0000) begin bad++; $display("FAIL rsthold_data: got %h expected 0000", instr_data); end
        total++; if (instr_pc !== 8'h00) begin bad++; $display("FAIL rsthold_ipc: got %h expected 00", instr_pc); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL rsthold_pc: got %h expected 00", pc); end
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL rsthold_addr: got %h expected 00", mem_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rsthold_busy: got %b expected 0", busy); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rsthold_halted: got %b expected 0", halted); end
    endtask

    // Random ready/redirect; model tracks only the address of the next
    // instruction decode should see.
    task automatic test_random;
        logic [7:0]  exp_pc;
        logic [7:0]  prev_ipc;
        logic [15:0] prev_data;
        logic        must_hold;
        int          gap;
        do_reset;
        start = 1'b1; tick; start = 1'b0;
        exp_pc = 8'h00; gap = 0; must_hold = 1'b0;
        prev_ipc = 8'h00; prev_data = 16'h0000;
        for (int c = 0; c < 800; c++) begin
            instr_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid  = ($urandom_range(0, 15) == 0);
            redirect_target = 8'($urandom);
            total++; if (mem_addr !== pc) begin bad++; $display("FAIL rnd_addr[%0d]: got %h expected %h", c, mem_addr, pc); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL rnd_busy[%0d]: got %b expected 1", c, busy); end
            if (must_hold) begin
                total++; if (instr_valid !== 1'b1 || instr_data !== prev_data || instr_pc !== prev_ipc) begin
                    bad++; $display("FAIL rnd_hold[%0d]: got %b/%h/%h expected 1/%h/%h", c, instr_valid, instr_data, instr_pc, prev_data, prev_ipc);
                end
            end
            if (instr_valid === 1'b1) begin
                total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL rnd_ipc[%0d]: got %h expected %h", c, instr_pc, exp_pc); end
                total++; if (instr_data !== mem[exp_pc]) begin bad++; $display("FAIL rnd_data[%0d]: got %h expected %h", c, instr_data, mem[exp_pc]); end
                gap = 0;
            end else begin
                gap++;
                total++; if (gap > 4) begin bad++; $display("FAIL rnd_stall[%0d]: got %0d idle cycles expected <= 4", c, gap); end
            end
            must_hold = (instr_valid === 1'b1) && !instr_ready && !redirect_valid;
            prev_data = instr_data; prev_ipc = instr_pc;
            if (instr_valid === 1'b1 && instr_ready) exp_pc = exp_pc + 8'd1;
            if (redirect_valid) begin exp_pc = redirect_target; gap = 0; end
            tick;
        end
        redirect_valid = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_halt;
        do_reset;
        mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'hF000; mem[3] = 16'h2222;
        instr_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
        tick; tick; tick; tick; tick; tick; tick; tick;
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL halt_valid: got %b expected 1", instr_valid); end
        total++; if (instr_data !== 16'hF000) begin bad++; $display("FAIL halt_data: got %h expected f000", instr_data); end
        total++; if (instr_pc !== 8'h02) begin bad++; $display("FAIL halt_ipc: got %h expected 02", instr_pc); end
        tick;
`ifdef FETCH_HALT_DETECT_EN
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_halted: got %b expected 1", halted); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL halt_busy: got %b expected 0", busy); end
        total++; if (pc !== 8'h03) begin bad++; $display("FAIL halt_pc: got %h expected 03", pc); end
        tick; tick; tick;
        total++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL halt_stay: got %b/%b expected 1/0", halted, instr_valid); end
        redirect_valid = 1'b1; redirect_target = 8'h00; tick; redirect_valid = 1'b0;
        total++; if (halted !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL halt_exit: got %b/%b expected 0/1", halted, busy); end
        total++; if (mem_addr !== 8'h00) begin bad++; $display("FAIL halt_exit_addr: got %h expected 00", mem_addr); end
        tick; tick;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_data !== 16'h1234) begin
            bad++; $display("FAIL halt_restart: got %b/%h/%h expected 1/00/1234", instr_valid, instr_pc, instr_data);
        end
`else
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL nohalt_halted: got %b expected 0", halted); end
        tick; tick;
        total++; if (instr_valid !== 1'b1 || instr_pc !== 8'h03 || instr_data !== 16'h2222) begin
            bad++; $display("FAIL nohalt_next: got %b/%h/%h expected 1/03/2222", instr_valid, instr_pc, instr_data);
        end
`endif
        instr_ready = 1'b0;
    endtask

    initial begin
        // Random words with bit 12 clear so no halt opcode appears by chance.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom) & 16'hEFFF;
        test_reset;
        test_basic;
        test_stall;
        test_wrap;
        test_redirect_resp;
        test_reset_hold;
        test_random;
        test_halt;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences the instruction fetch datapath: it owns the program counter, drives the address of the synchronous 256x16 instruction memory, captures returned words and hands them to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage. It also accepts branch redirects and, when configured, stops on a halt opcode.

## Interface
- No parameters; address width 8, instruction width 16, fixed.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins fetching from current pc when IDLE.
- redirect_valid  in  1  load new fetch address, flush in-flight fetch.
- redirect_target  in  8  new pc.
- mem_addr  out  8  instruction memory address; combinational, equals pc.
- mem_rdata  in  16  memory read data; valid the cycle after mem_addr is sampled.
- instr_valid  out  1  instr_data/instr_pc hold a fetched instruction.
- instr_ready  in  1  decode accepts instruction when high with instr_valid.
- instr_data  out  16  fetched instruction word (registered).
- instr_pc  out  8  address instr_data came from (registered).
- pc  out  8  current fetch address.
- busy  out  1  high in REQ, RESP, HOLD.
- halted  out  1  high in HALT.

## Operation
- States: IDLE, REQ, RESP, HOLD, HALT.
- IDLE: start=1 -> REQ. Other inputs except redirect ignored.
- REQ: mem_addr=pc presented; memory samples it at the closing edge -> RESP.
- RESP: instr_data<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (8-bit, 255 wraps to 0) -> HOLD.
- HOLD: instr_valid held high, instr_data/instr_pc stable until handshake. instr_ready=1 -> instr_valid<=0, next state REQ (or HALT, see Configuration).
- Redirect priority over everything else in the same cycle:
  - IDLE: pc<=redirect_target, stay IDLE (sets start address; start in same cycle still moves to REQ with the new pc).
  - REQ/RESP/HOLD: pc<=redirect_target, instr_valid<=0, RESP data discarded, -> REQ. A HOLD instruction with instr_ready=1 in the redirect cycle is still considered accepted by decode.
  - HALT: pc<=redirect_target, halted<=0, -> REQ.
- start outside IDLE ignored.
- reset in any state, including mid-handshake, returns to reset values next edge; in-flight word dropped.
- Throughput: one instruction per 3 cycles with instr_ready tied high.

## Timing
- Reset values: state IDLE, pc 0, mem_addr 0, instr_valid 0, instr_data 16'h0000, instr_pc 0, busy 0, halted 0.
- start at edge N -> REQ in cycle N+1, instr_valid high from cycle N+3.
- Redirect at edge N -> mem_addr=redirect_target in cycle N+1; instruction from target valid at N+3.
- instr_valid never drops without handshake, redirect or reset.
- busy, halted are state decodes (combinational).

## Configuration
- FETCH_HALT_DETECT_EN defined: in RESP, mem_rdata[15:12]==4'hF flags the word as halt. It is still delivered normally; on its HOLD handshake next state is HALT instead of REQ. pc already incremented past it. HALT exits only via redirect or reset.
- Undefined: no opcode decoding; HALT unreachable, halted tied 0.

## Test plan
- Reset, mem[0]=16'h1234, mem[1]=16'hABCD, instr_ready=1, pulse start -> instr_valid at cycle 3 with 16'h1234/pc 0, then 16'hABCD/pc 1 three cycles later.
- instr_ready=0 for 5 cycles in HOLD -> instr_valid, instr_data=16'h1234, instr_pc=0 stable; pc=1; no new mem_addr change until ready.
- In IDLE redirect to 8'hFE, start -> fetches 0xFE, 0xFF, then wraps to 0x00.
- Redirect to 8'h40 during RESP -> that word never presented, next instr_valid carries instr_pc 8'h40.
- Reset asserted in HOLD with instr_valid=1 -> next cycle all outputs at reset values, state IDLE.
- With FETCH_HALT_DETECT_EN, mem[2]=16'hF000 -> delivered, after handshake halted=1, busy=0, pc=3; redirect to 0 restarts fetching; without macro fetching continues to mem[3].
